// File: rtl/arbitro_eventos.sv
// Event front end for the needs controller: synchronizes and debounces the
// raw buttons and the proximity sensor, detects long presses on test and
// reset, and arbitrates events by fixed priority into a small command FIFO.
// It also owns the normal/test mode flag and the soft-reset pulse.
module arbitro_eventos #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 250000000,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       boton_curar,
  input  logic       boton_alimentar,
  input  logic       boton_limpiar,
  input  logic       boton_dormir,
  input  logic       boton_test,
  input  logic       boton_reset,
  input  logic       cercania,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       modo_test,
  output logic       reset_pulse,
  output logic       evento_perdido
);

  // Input index order doubles as arbitration priority (lowest index wins):
  // 0 curar, 1 alimentar, 2 limpiar, 3 dormir, 4 jugar (cercania),
  // 5 test, 6 reset. Reset never produces a command, only a long press.
  localparam int NIN      = 7;
  localparam int NEV      = 6;
  localparam int IDX_TEST = 5;
  localparam int IDX_RST  = 6;
  localparam int DBW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LPW      = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);

  logic [NIN-1:0] w_raw;
  logic [NIN-1:0] r_sync1, r_sync2, r_db;
  logic [NEV-1:0] r_db_d;
  logic [DBW-1:0] r_db_cnt [NIN];
  logic [LPW-1:0] r_lp_test, r_lp_rst;
  logic [NEV-1:0] w_rise, w_ev, w_grant, r_pend;
  logic [2:0]     w_grant_code;
  logic           w_fire_test, w_fire_rst;
  logic           w_full, w_push, w_pop, w_merge;
  logic [2:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_modo, r_lost;

  assign w_raw = {boton_reset, boton_test, cercania, boton_dormir,
                  boton_limpiar, boton_alimentar, boton_curar};

  // Two-flop synchronizer followed by a per-input stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int i = 0; i < NIN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db[NEV-1:0];
      for (int i = 0; i < NIN; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Long-press counters saturate one past the fire value so each hold fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lp_test <= '0;
      r_lp_rst  <= '0;
    end else begin
      if (!r_db[IDX_TEST])                            r_lp_test <= '0;
      else if (r_lp_test != LPW'(LONG_PRESS_CYCLES))  r_lp_test <= r_lp_test + 1'b1;
      if (!r_db[IDX_RST])                             r_lp_rst  <= '0;
      else if (r_lp_rst != LPW'(LONG_PRESS_CYCLES))   r_lp_rst  <= r_lp_rst + 1'b1;
    end
  end

  assign w_fire_test = r_db[IDX_TEST] && (r_lp_test == LPW'(LONG_PRESS_CYCLES - 1));
  assign w_fire_rst  = r_db[IDX_RST]  && (r_lp_rst  == LPW'(LONG_PRESS_CYCLES - 1));

  // In test mode only test_step survives; in normal mode test presses are silent.
  assign w_rise = r_db[NEV-1:0] & ~r_db_d;
  assign w_ev   = {w_rise[IDX_TEST] & r_modo, w_rise[IDX_TEST-1:0] & {IDX_TEST{~r_modo}}};

  // Fixed-priority pick of the lowest-index pending bit.
  always_comb begin
    w_grant      = '0;
    w_grant_code = 3'd0;
    for (int k = NEV - 1; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_grant      = NEV'(1) << k;
        w_grant_code = 3'(k + 1);
      end
    end
  end

  assign cmd_valid = (r_count != '0);
  assign cmd_code  = cmd_valid ? r_mem[r_rd_ptr] : 3'd0;
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = cmd_valid && cmd_ready && !w_fire_rst;
  assign w_push    = (|r_pend) && (!w_full || w_pop) && !w_fire_rst;
  // An event whose bit is being pushed this cycle refills it rather than merging.
  assign w_merge   = |(w_ev & r_pend & ~(w_grant & {NEV{w_push}}));

  // Pending bits, FIFO, mode and sticky loss flag; a reset long press overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_modo   <= 1'b0;
      r_lost   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 3'd0;
    end else if (w_fire_rst) begin
      r_pend   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_modo   <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~(w_grant & {NEV{w_push}})) | w_ev;
      if (w_merge)     r_lost <= 1'b1;
      if (w_fire_test) r_modo <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_grant_code;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign modo_test      = r_modo;
  assign evento_perdido = r_lost;
  assign reset_pulse    = w_fire_rst;

endmodule

// File: tb/tb_arbitro_eventos.sv
// Directed bench for arbitro_eventos with short debounce and long-press times.
`timescale 1ns/1ps
module tb_arbitro_eventos;

  localparam int DB    = 4;
  localparam int LP    = 50;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       boton_curar = 1'b0, boton_alimentar = 1'b0, boton_limpiar = 1'b0;
  logic       boton_dormir = 1'b0, boton_test = 1'b0, boton_reset = 1'b0;
  logic       cercania = 1'b0, cmd_ready = 1'b0;
  logic       cmd_valid, modo_test, reset_pulse, evento_perdido;
  logic [2:0] cmd_code;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  arbitro_eventos #(
    .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .boton_curar(boton_curar), .boton_alimentar(boton_alimentar),
    .boton_limpiar(boton_limpiar), .boton_dormir(boton_dormir),
    .boton_test(boton_test), .boton_reset(boton_reset),
    .cercania(cercania), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .modo_test(modo_test),
    .reset_pulse(reset_pulse), .evento_perdido(evento_perdido)
  );

  // Advance n rising edges; ends 1 ns after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int src, input logic v);
    case (src)
      0: boton_curar     = v;
      1: boton_alimentar = v;
      2: boton_limpiar   = v;
      3: boton_dormir    = v;
      4: cercania        = v;
      5: boton_test      = v;
      default: boton_reset = v;
    endcase
  endtask

  task automatic press(input int src, input int hi, input int lo);
    set_btn(src, 1'b1);
    tick(hi);
    set_btn(src, 1'b0);
    tick(lo);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    n_total++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); else n_pass++;
    n_total++; if (cmd_code !== 3'd0) $display("FAIL reset_cmd_code: got %0d want 0", cmd_code); else n_pass++;
    n_total++; if (modo_test !== 1'b0) $display("FAIL reset_modo_test: got %b want 0", modo_test); else n_pass++;
    n_total++; if (reset_pulse !== 1'b0) $display("FAIL reset_reset_pulse: got %b want 0", reset_pulse); else n_pass++;
    n_total++; if (evento_perdido !== 1'b0) $display("FAIL reset_evento_perdido: got %b want 0", evento_perdido); else n_pass++;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_latency();
    int first;
    first = -1;
    boton_curar = 1'b1;
    for (int k = 1; k <= 12 && first < 0; k++) begin
      tick(1);
      if (cmd_valid === 1'b1) first = k;
    end
    n_total++; if (first != DB + 4) $display("FAIL latency_edges: got %0d want %0d", first, DB + 4); else n_pass++;
    n_total++; if (cmd_code !== 3'd1) $display("FAIL latency_code: got %0d want 1", cmd_code); else n_pass++;
    tick(20 - first);
    n_total++; if (cmd_valid !== 1'b1) $display("FAIL hold_valid: got %b want 1", cmd_valid); else n_pass++;
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    n_total++; if (cmd_valid !== 1'b0) $display("FAIL hold_single_entry: got valid %b want 0", cmd_valid); else n_pass++;
    boton_curar = 1'b0;
    tick(12);
    n_total++; if (cmd_valid !== 1'b0) $display("FAIL release_no_event: got valid %b want 0", cmd_valid); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int codes[$];
    int idx[$];
    int exp_code[3] = '{2, 4, 5};
    int got;
    cmd_ready = 1'b1;
    boton_alimentar = 1'b1; boton_dormir = 1'b1; cercania = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (cmd_valid && cmd_ready) begin
        codes.push_back(int'(cmd_code));
        idx.push_back(k);
      end
      tick(1);
    end
    boton_alimentar = 1'b0; boton_dormir = 1'b0; cercania = 1'b0;
    cmd_ready = 1'b0;
    n_total++; if (codes.size() != 3) $display("FAIL simul_count: got %0d want 3", codes.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      got = (i < codes.size()) ? codes[i] : -1;
      n_total++; if (got != exp_code[i]) $display("FAIL simul_code%0d: got %0d want %0d", i, got, exp_code[i]); else n_pass++;
    end
    got = (idx.size() == 3) ? idx[2] - idx[0] : -1;
    n_total++; if (got != 2) $display("FAIL simul_consecutive: got span %0d want 2", got); else n_pass++;
    tick(12);
  endtask

  task automatic test_fifo_full();
    int codes[$];
    int exp_code[6] = '{1, 2, 3, 4, 5, 1};
    int got;
    cmd_ready = 1'b0;
    for (int s = 0; s < 5; s++) press(s, 8, 12);
    n_total++; if (cmd_code !== 3'd1) $display("FAIL full_head: got %0d want 1", cmd_code); else n_pass++;
    n_total++; if (evento_perdido !== 1'b0) $display("FAIL full_no_loss: got %b want 0", evento_perdido); else n_pass++;
    // The sixth press overlaps the drain so curar becomes pending after jugar left.
    boton_curar = 1'b1;
    cmd_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (cmd_valid && cmd_ready) codes.push_back(int'(cmd_code));
      tick(1);
      if (k == 8) boton_curar = 1'b0;
    end
    cmd_ready = 1'b0;
    n_total++; if (codes.size() != 6) $display("FAIL drain_count: got %0d want 6", codes.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      got = (i < codes.size()) ? codes[i] : -1;
      n_total++; if (got != exp_code[i]) $display("FAIL drain_code%0d: got %0d want %0d", i, got, exp_code[i]); else n_pass++;
    end
    n_total++; if (evento_perdido !== 1'b0) $display("FAIL drain_no_loss: got %b want 0", evento_perdido); else n_pass++;
    tick(5);
  endtask

  task automatic test_long_press_test();
    int first;
    int seen;
    first = -1;
    seen = 0;
    cmd_ready = 1'b0;
    boton_test = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      if (modo_test === 1'b1 && first < 0) first = k;
      if (cmd_valid === 1'b1) seen = 1;
    end
    boton_test = 1'b0;
    n_total++; if (first != LP + 6) $display("FAIL lp_test_edge: got %0d want %0d", first, LP + 6); else n_pass++;
    n_total++; if (seen != 0) $display("FAIL lp_test_no_entry: got valid seen %0d want 0", seen); else n_pass++;
    tick(12);
    press(5, 8, 12);
    n_total++; if (cmd_valid !== 1'b1) $display("FAIL test_step_valid: got %b want 1", cmd_valid); else n_pass++;
    n_total++; if (cmd_code !== 3'd6) $display("FAIL test_step_code: got %0d want 6", cmd_code); else n_pass++;
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    seen = 0;
    boton_curar = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 8) boton_curar = 1'b0;
      if (cmd_valid === 1'b1) seen = 1;
    end
    n_total++; if (seen != 0) $display("FAIL test_mode_filter: got valid seen %0d want 0", seen); else n_pass++;
    n_total++; if (evento_perdido !== 1'b0) $display("FAIL test_mode_no_loss: got %b want 0", evento_perdido); else n_pass++;
    n_total++; if (modo_test !== 1'b1) $display("FAIL test_mode_held: got %b want 1", modo_test); else n_pass++;
  endtask

  task automatic test_reset_long_press();
    int first;
    int pulses;
    logic v_at, v_post, m_post, l_post;
    first = -1;
    pulses = 0;
    v_at = 1'b0; v_post = 1'b1; m_post = 1'b1; l_post = 1'b1;
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) press(5, 8, 12);
    n_total++; if (cmd_code !== 3'd6) $display("FAIL queued_code: got %0d want 6", cmd_code); else n_pass++;
    boton_reset = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick(1);
      if (reset_pulse === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = k;
          v_at = cmd_valid;
        end
      end
      if (first > 0 && k == first + 1) begin
        v_post = cmd_valid;
        m_post = modo_test;
        l_post = evento_perdido;
      end
    end
    boton_reset = 1'b0;
    n_total++; if (first != LP + 5) $display("FAIL rst_lp_edge: got %0d want %0d", first, LP + 5); else n_pass++;
    n_total++; if (pulses != 1) $display("FAIL rst_pulse_width: got %0d want 1", pulses); else n_pass++;
    n_total++; if (v_at !== 1'b1) $display("FAIL rst_valid_at_pulse: got %b want 1", v_at); else n_pass++;
    n_total++; if (v_post !== 1'b0) $display("FAIL rst_flush: got valid %b want 0", v_post); else n_pass++;
    n_total++; if (m_post !== 1'b0) $display("FAIL rst_modo: got %b want 0", m_post); else n_pass++;
    n_total++; if (l_post !== 1'b0) $display("FAIL rst_lost: got %b want 0", l_post); else n_pass++;
    tick(12);
    cmd_ready = 1'b1;
    tick(3);
    n_total++; if (cmd_valid !== 1'b0) $display("FAIL rst_nothing_pending: got valid %b want 0", cmd_valid); else n_pass++;
    cmd_ready = 1'b0;
  endtask

  task automatic test_merge();
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) press(0, 8, 12);
    n_total++; if (evento_perdido !== 1'b0) $display("FAIL merge_before: got %b want 0", evento_perdido); else n_pass++;
    press(0, 8, 12);
    n_total++; if (evento_perdido !== 1'b1) $display("FAIL merge_set: got %b want 1", evento_perdido); else n_pass++;
    cmd_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (cmd_valid && cmd_ready) begin
        cnt++;
        if (cmd_code !== 3'd1) bad++;
      end
      tick(1);
    end
    cmd_ready = 1'b0;
    n_total++; if (cnt != 5) $display("FAIL merge_drain_count: got %0d want 5", cnt); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL merge_drain_codes: got %0d non-curar want 0", bad); else n_pass++;
    n_total++; if (evento_perdido !== 1'b1) $display("FAIL merge_sticky: got %b want 1", evento_perdido); else n_pass++;
  endtask

  task automatic test_async_reset();
    int first;
    int seen_pulse;
    logic [2:0] code_at;
    first = -1;
    seen_pulse = 0;
    code_at = 3'd0;
    cmd_ready = 1'b0;
    press(2, 8, 12);
    boton_reset = 1'b1;
    tick(20);
    boton_curar = 1'b1;
    tick(4);
    n_total++; if (cmd_valid !== 1'b1) $display("FAIL pre_arst_valid: got %b want 1", cmd_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (cmd_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", cmd_valid); else n_pass++;
    n_total++; if (cmd_code !== 3'd0) $display("FAIL arst_code: got %0d want 0", cmd_code); else n_pass++;
    n_total++; if (evento_perdido !== 1'b0) $display("FAIL arst_lost: got %b want 0", evento_perdido); else n_pass++;
    n_total++; if (modo_test !== 1'b0 || reset_pulse !== 1'b0) $display("FAIL arst_flags: got modo %b pulse %b want 0 0", modo_test, reset_pulse); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (cmd_valid === 1'b1 && first < 0) begin
        first = k;
        code_at = cmd_code;
      end
      if (reset_pulse === 1'b1) seen_pulse = 1;
    end
    boton_curar = 1'b0;
    boton_reset = 1'b0;
    n_total++; if (first != DB + 4) $display("FAIL arst_fresh_debounce: got %0d want %0d", first, DB + 4); else n_pass++;
    n_total++; if (code_at !== 3'd1) $display("FAIL arst_code_after: got %0d want 1", code_at); else n_pass++;
    n_total++; if (seen_pulse != 0) $display("FAIL arst_lp_restart: got pulse seen %0d want 0", seen_pulse); else n_pass++;
    tick(12);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_simultaneous();
    test_fifo_full();
    test_long_press_test();
    test_reset_long_press();
    test_merge();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
